// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the multi-channel pulse generator: channel FSM
// state encodings and small constant helpers used for counter sizing.
package pulse_gen_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PULSE   = 2'd1;
    localparam logic [1:0] ST_HOLDOFF = 2'd2;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // A programmed width of zero still produces a single-cycle pulse.
    function automatic logic [31:0] max_width(input logic [31:0] w);
        return (w == 32'd0) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/pulse_gen_multi_if.sv
// Control/status bundle between the event sources and the pulse generator.
interface pulse_gen_multi_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH_W  = 8
) ();

    logic [CHANNELS-1:0] en;
    logic [CHANNELS-1:0] sig;
    logic [WIDTH_W-1:0]  width;
    logic [CHANNELS-1:0] retrig;
    logic [CHANNELS-1:0] clear_missed;
    logic [CHANNELS-1:0] pulse;
    logic [CHANNELS-1:0] busy;
    logic [CHANNELS-1:0] missed;

    modport master (
        output en, sig, width, retrig, clear_missed,
        input  pulse, busy, missed
    );

    modport slave (
        input  en, sig, width, retrig, clear_missed,
        output pulse, busy, missed
    );

endinterface

// File: rtl/pulse_gen_channel.sv
// One pulse channel: rising-edge detect, IDLE/PULSE/HOLDOFF sequencer with a
// shared down-counter, and a sticky flag for triggers that were not accepted.
module pulse_gen_channel
    import pulse_gen_pkg::*;
#(
    parameter int WIDTH_W = 8,
    parameter int HOLDOFF = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               en_i,
    input  logic               sig_i,
    input  logic [WIDTH_W-1:0] width_i,
    input  logic               retrig_i,
    input  logic               clear_missed_i,
    output logic               pulse_o,
    output logic               busy_o,
    output logic               missed_o
);

    localparam int CNT_W = imax(WIDTH_W, imax($clog2(HOLDOFF + 1), 1));

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sig_q;
    logic             missed_q, missed_d;
    logic             pulse_q, busy_q;

    logic             trigger;
    logic             lastCycle;
    logic             acceptTrig;
    logic             rejectTrig;
    logic [CNT_W-1:0] loadVal;

    always_comb begin
        trigger   = sig_i & ~sig_q & en_i;
        lastCycle = (cnt_q == CNT_W'(1));
        loadVal   = CNT_W'(max_width(32'(width_i)));

        // The final cycle of PULSE (no holdoff) or HOLDOFF already counts as
        // free, so a trigger sampled there starts a new pulse back to back.
        acceptTrig = 1'b0;
        case (state_q)
            ST_IDLE:    acceptTrig = trigger;
            ST_PULSE:   acceptTrig = trigger & (retrig_i | (lastCycle & (HOLDOFF == 0)));
            ST_HOLDOFF: acceptTrig = trigger & lastCycle;
            default:    acceptTrig = trigger;
        endcase
        rejectTrig = trigger & ~acceptTrig;

        state_d = state_q;
        cnt_d   = cnt_q;
        if (!en_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (acceptTrig) begin
            state_d = ST_PULSE;
            cnt_d   = loadVal;
        end else begin
            case (state_q)
                ST_PULSE: begin
                    if (!lastCycle) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (HOLDOFF > 0) begin
                        state_d = ST_HOLDOFF;
                        cnt_d   = CNT_W'(HOLDOFF);
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_HOLDOFF: begin
                    if (lastCycle) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        missed_d = rejectTrig | (missed_q & ~clear_missed_i);
    end

    // sig_q resets high so a level already present at reset release is not an edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sig_q    <= 1'b1;
            missed_q <= 1'b0;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sig_q    <= sig_i;
            missed_q <= missed_d;
            pulse_q  <= (state_d == ST_PULSE);
            busy_q   <= (state_d != ST_IDLE);
        end
    end

    assign pulse_o  = pulse_q;
    assign busy_o   = busy_q;
    assign missed_o = missed_q;

    acceptRaisesPulse: assert property (
        @(posedge clock) disable iff (!reset_n) acceptTrig |=> pulse_o
    );

    pulseEndsAfterCount: assert property (
        @(posedge clock) disable iff (!reset_n)
        (state_q == ST_PULSE && lastCycle && !acceptTrig) |=> !pulse_o
    );

endmodule

// File: rtl/pulse_gen_multi.sv
// Multi-channel programmable pulse generator: independent channels sharing
// one pulse-width setting.
module pulse_gen_multi
    import pulse_gen_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH_W  = 8,
    parameter int HOLDOFF  = 2
) (
    input logic               clock,
    input logic               reset_n,
    pulse_gen_multi_if.slave  bus
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pulse_gen_channel #(
            .WIDTH_W (WIDTH_W),
            .HOLDOFF (HOLDOFF)
        ) u_channel (
            .clock          (clock),
            .reset_n        (reset_n),
            .en_i           (bus.en[g]),
            .sig_i          (bus.sig[g]),
            .width_i        (bus.width),
            .retrig_i       (bus.retrig[g]),
            .clear_missed_i (bus.clear_missed[g]),
            .pulse_o        (bus.pulse[g]),
            .busy_o         (bus.busy[g]),
            .missed_o       (bus.missed[g])
        );
    end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Directed testbench for pulse_gen_multi (4 channels, 8-bit width, holdoff 2).
module tb_pulse_gen_multi;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    pulse_gen_multi_if #(.CHANNELS(4), .WIDTH_W(8)) bus ();

    pulse_gen_multi #(
        .CHANNELS (4),
        .WIDTH_W  (8),
        .HOLDOFF  (2)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    // Fire one rising edge on a channel and record the pulse/busy window,
    // sampled on each falling edge after the trigger-sampling edge.
    task automatic fireAndMeasure(input int ch, input int cycles,
                                  output int pulseCnt, output int busyCnt,
                                  output int firstIdx, output int lastIdx);
        pulseCnt = 0;
        busyCnt  = 0;
        firstIdx = -1;
        lastIdx  = -1;
        @(negedge clock);
        bus.sig[ch] = 1'b0;
        @(negedge clock);
        bus.sig[ch] = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (bus.pulse[ch]) begin
                pulseCnt++;
                if (firstIdx < 0) firstIdx = i;
                lastIdx = i;
            end
            if (bus.busy[ch]) busyCnt++;
            if (i == 0) bus.sig[ch] = 1'b0;
        end
    endtask

    task automatic test_reset();
        int cnt;
        checks++;
        if (bus.pulse !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_pulse got %b expected 0000", bus.pulse);
        end
        checks++;
        if (bus.busy !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_busy got %b expected 0000", bus.busy);
        end
        checks++;
        if (bus.missed !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_missed got %b expected 0000", bus.missed);
        end
        @(negedge clock);
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (bus.pulse[0]) cnt++;
        end
        checks++;
        if (cnt !== 0) begin
            errors++;
            $display("[TB] FAIL high_at_release got %0d pulse cycles expected 0", cnt);
        end
    endtask

    task automatic test_single();
        int pc, bc, fi, li;
        bus.width = 8'd5;
        fireAndMeasure(0, 15, pc, bc, fi, li);
        checks++;
        if (pc !== 5) begin
            errors++;
            $display("[TB] FAIL single_width got %0d expected 5", pc);
        end
        checks++;
        if (bc !== 7) begin
            errors++;
            $display("[TB] FAIL single_busy got %0d expected 7", bc);
        end
        checks++;
        if (fi !== 0) begin
            errors++;
            $display("[TB] FAIL single_latency got %0d expected 0", fi);
        end
        checks++;
        if (li !== 4) begin
            errors++;
            $display("[TB] FAIL single_last got %0d expected 4", li);
        end
    endtask

    task automatic test_oneshot_missed();
        int pc, li, mf;
        pc = 0;
        li = -1;
        mf = -1;
        bus.width     = 8'd6;
        bus.retrig[1] = 1'b0;
        @(negedge clock);
        bus.sig[1] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            if (bus.pulse[1]) begin
                pc++;
                li = i;
            end
            if (bus.missed[1] && mf < 0) mf = i;
            if (i == 0) bus.sig[1] = 1'b0;
            if (i == 2) bus.sig[1] = 1'b1;
        end
        checks++;
        if (pc !== 6 || li !== 5) begin
            errors++;
            $display("[TB] FAIL oneshot_width got %0d cycles ending at %0d expected 6 ending at 5", pc, li);
        end
        checks++;
        if (mf !== 3) begin
            errors++;
            $display("[TB] FAIL oneshot_missed_time got %0d expected 3", mf);
        end
        checks++;
        if (bus.missed[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL missed_sticky got %b expected 1", bus.missed[1]);
        end
        @(negedge clock);
        bus.clear_missed[1] = 1'b1;
        @(negedge clock);
        bus.clear_missed[1] = 1'b0;
        bus.sig[1]          = 1'b0;
        checks++;
        if (bus.missed[1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL missed_clear got %b expected 0", bus.missed[1]);
        end
    endtask

    task automatic test_retrig();
        int pc, bc, li;
        logic sawMissed;
        pc = 0;
        bc = 0;
        li = -1;
        sawMissed = 1'b0;
        bus.width     = 8'd4;
        bus.retrig[2] = 1'b1;
        @(negedge clock);
        bus.sig[2] = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            if (bus.pulse[2]) begin
                pc++;
                li = i;
            end
            if (bus.busy[2]) bc++;
            if (bus.missed[2]) sawMissed = 1'b1;
            if (i == 0) bus.sig[2] = 1'b0;
            if (i == 1) bus.sig[2] = 1'b1;
        end
        bus.sig[2] = 1'b0;
        checks++;
        if (pc !== 6) begin
            errors++;
            $display("[TB] FAIL retrig_width got %0d expected 6", pc);
        end
        checks++;
        if (li !== 5) begin
            errors++;
            $display("[TB] FAIL retrig_continuous got last %0d expected 5", li);
        end
        checks++;
        if (bc !== 8) begin
            errors++;
            $display("[TB] FAIL retrig_busy got %0d expected 8", bc);
        end
        checks++;
        if (sawMissed !== 1'b0) begin
            errors++;
            $display("[TB] FAIL retrig_missed got %b expected 0", sawMissed);
        end
    endtask

    task automatic test_holdoff();
        int early, late, lateFirst, mf;
        early = 0;
        late = 0;
        lateFirst = -1;
        mf = -1;
        bus.width     = 8'd3;
        bus.retrig[3] = 1'b0;
        @(negedge clock);
        bus.sig[3] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.pulse[3]) begin
                if (i < 9) early++;
                else begin
                    late++;
                    if (lateFirst < 0) lateFirst = i;
                end
            end
            if (bus.missed[3] && mf < 0) mf = i;
            if (i == 0 || i == 6) bus.sig[3] = 1'b0;
            if (i == 3 || i == 8) bus.sig[3] = 1'b1;
        end
        checks++;
        if (early !== 3) begin
            errors++;
            $display("[TB] FAIL holdoff_no_pulse got %0d cycles expected 3", early);
        end
        checks++;
        if (mf !== 4) begin
            errors++;
            $display("[TB] FAIL holdoff_missed_time got %0d expected 4", mf);
        end
        checks++;
        if (late !== 3 || lateFirst !== 9) begin
            errors++;
            $display("[TB] FAIL after_holdoff got %0d cycles from %0d expected 3 from 9", late, lateFirst);
        end
        @(negedge clock);
        bus.sig[3] = 1'b0;
        @(negedge clock);
        bus.sig[3] = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clock);
            if (j == 2) begin
                checks++;
                if (bus.missed[3] !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL set_beats_clear got %b expected 1", bus.missed[3]);
                end
            end
            if (j == 0) bus.sig[3] = 1'b0;
            if (j == 1) begin
                bus.sig[3]          = 1'b1;
                bus.clear_missed[3] = 1'b1;
            end
            if (j == 2) bus.clear_missed[3] = 1'b0;
        end
        bus.clear_missed[3] = 1'b1;
        @(negedge clock);
        bus.clear_missed[3] = 1'b0;
        bus.sig[3]          = 1'b0;
        checks++;
        if (bus.missed[3] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL holdoff_clear got %b expected 0", bus.missed[3]);
        end
    endtask

    task automatic test_width_limits();
        int pc, bc, fi, li;
        bus.width = 8'd0;
        fireAndMeasure(0, 8, pc, bc, fi, li);
        checks++;
        if (pc !== 1 || fi !== 0) begin
            errors++;
            $display("[TB] FAIL width0 got %0d cycles from %0d expected 1 from 0", pc, fi);
        end
        checks++;
        if (bc !== 3) begin
            errors++;
            $display("[TB] FAIL width0_busy got %0d expected 3", bc);
        end
        bus.width = 8'd255;
        fireAndMeasure(0, 270, pc, bc, fi, li);
        checks++;
        if (pc !== 255 || li !== 254) begin
            errors++;
            $display("[TB] FAIL width255 got %0d cycles ending %0d expected 255 ending 254", pc, li);
        end
        checks++;
        if (bc !== 257) begin
            errors++;
            $display("[TB] FAIL width255_busy got %0d expected 257", bc);
        end
    endtask

    task automatic test_all_channels();
        int pc[4];
        int fi[4];
        bus.width = 8'd3;
        bus.sig   = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            pc[c] = 0;
            fi[c] = -1;
        end
        @(negedge clock);
        @(negedge clock);
        bus.sig = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            for (int c = 0; c < 4; c++) begin
                if (bus.pulse[c]) begin
                    pc[c]++;
                    if (fi[c] < 0) fi[c] = i;
                end
            end
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (pc[c] !== 3 || fi[c] !== 0) begin
                errors++;
                $display("[TB] FAIL all_ch%0d got %0d cycles from %0d expected 3 from 0", c, pc[c], fi[c]);
            end
        end
    endtask

    task automatic test_disable_and_reset();
        int cnt;
        bus.width = 8'd10;
        bus.sig   = 4'b0000;
        @(negedge clock);
        @(negedge clock);
        bus.sig[1:0] = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
        end
        bus.en[1] = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.pulse[1] !== 1'b0 || bus.busy[1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL en_drop got pulse %b busy %b expected 0 0", bus.pulse[1], bus.busy[1]);
        end
        checks++;
        if (bus.pulse[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL neighbour_unaffected got %b expected 1", bus.pulse[0]);
        end
        bus.sig[1] = 1'b0;
        @(negedge clock);
        bus.sig[1] = 1'b1;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (bus.missed[1] !== 1'b0 || bus.pulse[1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL disabled_edge got missed %b pulse %b expected 0 0", bus.missed[1], bus.pulse[1]);
        end
        checks++;
        if (bus.pulse[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_reset_pulse got %b expected 1", bus.pulse[0]);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.pulse !== 4'b0000 || bus.busy !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL async_reset got pulse %b busy %b expected 0000 0000", bus.pulse, bus.busy);
        end
        @(negedge clock);
        reset_n   = 1'b1;
        bus.en[1] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (bus.pulse[1:0] != 2'b00) cnt++;
        end
        checks++;
        if (cnt !== 0) begin
            errors++;
            $display("[TB] FAIL no_stale_trigger got %0d pulse cycles expected 0", cnt);
        end
        bus.sig[0] = 1'b0;
        @(negedge clock);
        bus.sig[0] = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.pulse[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fresh_edge got %b expected 1", bus.pulse[0]);
        end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        reset_n          = 1'b0;
        bus.en           = 4'b1111;
        bus.sig          = 4'b0001;
        bus.width        = 8'd5;
        bus.retrig       = 4'b0000;
        bus.clear_missed = 4'b0000;
        #12;
        $display("[TB] starting pulse_gen_multi tests");
        test_reset();
        test_single();
        test_oneshot_missed();
        test_retrig();
        test_holdoff();
        test_width_limits();
        test_all_channels();
        test_disable_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_gen_multi.md
# pulse_gen_multi

Multi-channel, run-time-programmable pulse generator: each channel detects a rising edge on its input and drives an output pulse of programmable width. Beyond the single-channel fixed-width pulse FSM, it adds retrigger mode, post-pulse holdoff, per-channel enable and a sticky missed-trigger flag. It sits between synchronous event sources and downstream strobe consumers.

## Interface
- CHANNELS, 4, number of independent channels
- WIDTH_W, 8, bit width of the pulse-width value (max pulse 2^WIDTH_W-1 cycles)
- HOLDOFF, 2, cycles pulse stays low after a pulse before a new trigger is accepted (0 = none)

- clock  in  1  single clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- en  in  CHANNELS  per-channel enable
- sig  in  CHANNELS  trigger inputs, synchronous to clock
- width  in  WIDTH_W  pulse width in cycles, shared, sampled at trigger
- retrig  in  CHANNELS  per-channel mode: 0 one-shot, 1 retriggerable
- clear_missed  in  CHANNELS  clears the matching missed flag
- pulse  out  CHANNELS  pulse outputs, registered
- busy  out  CHANNELS  channel in PULSE or HOLDOFF
- missed  out  CHANNELS  sticky: trigger arrived and was not accepted

## Operation
- Per channel: sig_q register; trigger = sig & ~sig_q & en.
- States: IDLE, PULSE, HOLDOFF.
- IDLE: on trigger, load cnt = max(width,1), go PULSE.
- PULSE: pulse = 1; cnt decrements each cycle; when cnt == 1, go HOLDOFF (HOLDOFF > 0, cnt = HOLDOFF) or IDLE (HOLDOFF = 0).
- Trigger in PULSE, retrig = 1: reload cnt = max(width,1); pulse stays high. No missed flag.
- Trigger in PULSE, retrig = 0: ignored; set missed.
- HOLDOFF: pulse = 0; cnt decrements; at cnt == 1, go IDLE. A trigger here is ignored and sets missed.
- width 0 is treated as 1; width changes mid-pulse have no effect unless a retrigger reloads.
- en low: channel goes IDLE on next edge, pulse and busy fall; cnt cleared; sig_q keeps tracking sig; missed unchanged; edges while disabled are not triggers and do not set missed.
- missed: set wins over simultaneous clear_missed; otherwise cleared by clear_missed.
- Channels fully independent; same-cycle triggers on all channels are each handled.

## Timing
- Reset (reset_n low, async): pulse = 0, busy = 0, missed = 0, state IDLE, cnt = 0, sig_q = 1 (a level already high at reset release is not a trigger).
- Latency: trigger sampled at edge k -> pulse high from edge k through edge k+W, i.e. exactly W consecutive cycles for W = max(width,1).
- Holdoff: after the last pulse cycle, pulse low and busy high for exactly HOLDOFF cycles; first acceptable trigger is sampled at edge k+W+HOLDOFF.
- Retrigger at edge j within a pulse: pulse remains high through edge j+W' (W' = width at j); no low glitch.
- Reset asserted mid-pulse: pulse drops immediately (asynchronous); first trigger accepted is a fresh rising edge after release.
- busy is registered and coincident with state; missed asserts the cycle after the rejected trigger edge.

## Structure
- Package pulse_gen_pkg: state enum (IDLE, PULSE, HOLDOFF), max-width helper constant function.
- Sub-module pulse_gen_channel: one channel's edge detector, FSM, counter and missed flag; top is a generate loop over CHANNELS plus shared width fan-out.

## Test plan
- Reset release with sig[0] = 1, width = 5 -> no pulse; then sig[0] 0->1 -> pulse[0] high exactly 5 cycles, busy high 7 cycles (HOLDOFF = 2).
- retrig[1] = 0, width = 6, second rising edge 3 cycles into the pulse -> pulse stays 6 cycles total, missed[1] = 1 the next cycle; clear_missed[1] -> 0.
- retrig[2] = 1, width = 4, second edge 2 cycles into pulse -> pulse high 2 + 4 = 6 continuous cycles, missed[2] = 0.
- Edge during HOLDOFF on channel 3 -> no pulse, missed[3] = 1; edge after holdoff -> normal pulse; clear_missed coincident with a new rejection -> missed stays 1.
- width = 0 -> 1-cycle pulse; width = 255 -> 255-cycle pulse; all four channels triggered same cycle with width = 3 -> four identical 3-cycle pulses.
- reset_n pulled low mid-pulse and en dropped mid-pulse on another channel -> pulse low immediately / next edge respectively; assertion: $rose accepted trigger |=> pulse[*W] ##1 ~pulse.
